// File: rtl/life_step_sequencer.sv
// Turns periodic timer ticks and manual step requests into start/done generation
// transactions for the Game of Life cell array, with overrun and timeout reporting.
module life_step_sequencer #(
  parameter int unsigned TICKS_PER_STEP = 1,
  parameter int unsigned GEN_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_pulse,
  input  logic                 run,
  input  logic                 step_req,
  input  logic                 step_done,
  input  logic                 clear_err,
  output logic                 step_start,
  output logic                 busy,
  output logic [GEN_WIDTH-1:0] generation,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int unsigned TickW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_STEP - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

  state_e               state_q, state_d;
  logic                 tick_q, step_q;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [GEN_WIDTH-1:0] gen_q, gen_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;
  logic                 tick_rise, step_rise, auto_req, req;
  logic                 overrun_set, timeout_set;

  assign tick_rise = tick_pulse & ~tick_q;
  assign step_rise = step_req & ~step_q;
  assign req       = auto_req | step_rise;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    auto_req   = 1'b0;
    if (!run) begin
      tick_cnt_d = '0;
    end else if (tick_rise) begin
      if (tick_cnt_q == TickLast) begin
        auto_req   = 1'b1;
        tick_cnt_d = '0;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    gen_d       = gen_q;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) state_d = StStart;
      end
      StStart: begin
        state_d    = StWait;
        wait_cnt_d = '0;
      end
      StWait: begin
        if (step_done) begin
          gen_d   = gen_q + 1'b1;
          state_d = StIdle;
        end else if (wait_cnt_q == WaitLast) begin
          timeout_set = 1'b1;
          state_d     = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Requests arriving outside IDLE are never queued; only auto requests are flagged.
  assign overrun_set = auto_req & (state_q != StIdle);
  // Set beats clear when both happen in one cycle.
  assign overrun_d   = overrun_set | (overrun_q & ~clear_err);
  assign timeout_d   = timeout_set | (timeout_q & ~clear_err);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      tick_q     <= 1'b0;
      step_q     <= 1'b0;
      tick_cnt_q <= '0;
      wait_cnt_q <= '0;
      gen_q      <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_pulse;
      step_q     <= step_req;
      tick_cnt_q <= tick_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      gen_q      <= gen_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign step_start  = (state_q == StStart);
  assign busy        = (state_q != StIdle);
  assign generation  = gen_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_life_step_sequencer.sv
// Randomized bench for life_step_sequencer: a transaction-level reference model
// feeds a scoreboard queue that an independent monitor drains every clock.
module tb_life_step_sequencer;

  localparam int unsigned Tps = 3;
  localparam int unsigned Gw  = 4;
  localparam int unsigned To  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick_pulse = 1'b0;
  logic          run = 1'b0;
  logic          step_req = 1'b0;
  logic          step_done = 1'b0;
  logic          clear_err = 1'b0;
  logic          step_start;
  logic          busy;
  logic [Gw-1:0] generation;
  logic          overrun;
  logic          timeout_err;

  life_step_sequencer #(
    .TICKS_PER_STEP(Tps),
    .GEN_WIDTH     (Gw),
    .TIMEOUT_CYCLES(To)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_pulse (tick_pulse),
    .run        (run),
    .step_req   (step_req),
    .step_done  (step_done),
    .clear_err  (clear_err),
    .step_start (step_start),
    .busy       (busy),
    .generation (generation),
    .overrun    (overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          start;
    logic          busy;
    logic [Gw-1:0] gen;
    logic          ov;
    logic          to;
  } obs_t;

  obs_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: a step is "in flight" from acceptance until done or timeout;
  // age counts clocks since acceptance (age 0 is the start cycle).
  int ticks_m = 0;
  bit in_flight = 0;
  int age = 0;
  int gen_m = 0;
  bit ov_m = 0, to_m = 0;
  bit tick_prev = 0, step_prev = 0;

  always @(posedge clk) begin
    bit tr, sr, auto_r, ov_set, to_set;
    obs_t e;
    if (!rst) begin
      ticks_m = 0; in_flight = 0; age = 0; gen_m = 0;
      ov_m = 0; to_m = 0; tick_prev = 0; step_prev = 0;
    end else begin
      tr = tick_pulse && !tick_prev;
      sr = step_req && !step_prev;
      auto_r = 0;
      if (run) begin
        if (tr) begin
          ticks_m++;
          if (ticks_m % Tps == 0) auto_r = 1;
        end
      end else begin
        ticks_m = 0;
      end
      ov_set = auto_r && in_flight;
      to_set = 0;
      if (in_flight) begin
        if (age >= 1 && step_done) begin
          gen_m++;
          in_flight = 0;
        end else if (age >= To) begin
          to_set = 1;
          in_flight = 0;
        end else begin
          age++;
        end
      end else if (auto_r || sr) begin
        in_flight = 1;
        age = 0;
      end
      ov_m = ov_set || (ov_m && !clear_err);
      to_m = to_set || (to_m && !clear_err);
      tick_prev = tick_pulse;
      step_prev = step_req;
    end
    e.start = in_flight && (age == 0);
    e.busy  = in_flight;
    e.gen   = Gw'(gen_m % (1 << Gw));
    e.ov    = ov_m;
    e.to    = to_m;
    sb_q.push_back(e);
  end

  // Monitor: compares each clock's outputs, and checks async clearing when rst falls.
  always @(posedge clk or negedge rst) begin
    obs_t a, e;
    if (!rst && !clk) begin
      #1;
      a = '{step_start, busy, generation, overrun, timeout_err};
      vectors++;
      if (a !== '0) begin
        miscompares++;
        $display("FAIL async_reset t=%0t actual=%b required=%b", $time, a, obs_t'('0));
      end
    end else begin
      #1;
      a = '{step_start, busy, generation, overrun, timeout_err};
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty t=%0t actual=%b required=<entry>", $time, a);
      end else begin
        e = sb_q.pop_front();
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle_check t=%0t actual start=%0b busy=%0b gen=%0d ov=%0b to=%0b required start=%0b busy=%0b gen=%0d ov=%0b to=%0b",
                   $time, a.start, a.busy, a.gen, a.ov, a.to,
                   e.start, e.busy, e.gen, e.ov, e.to);
        end
      end
    end
  end

  int done_timer = 0;
  int resets = 0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      tick_pulse = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) run = ~run;
      if ($urandom_range(0, 9) == 0) step_req = ~step_req;
      clear_err = ($urandom_range(0, 29) == 0);
      step_done = 1'b0;
      if (step_start) done_timer = $urandom_range(1, 11);
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) step_done = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        step_done = 1'b1;
      end
      if (busy && ((resets == 0 && i >= 2000) || (resets == 1 && i >= 4500))) begin
        resets++;
        #2 rst = 1'b0;
        @(negedge clk);
        step_done = 1'b1;
        @(negedge clk);
        step_done = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        done_timer = 0;
      end
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
